stopwatch_ctrl: RTL

Control and timebase block for the DE10-Lite stopwatch. It debounces the two push-buttons and runs the start/stop/lap/clear state machine. It derives a centisecond tick from the board clock and keeps a six-digit BCD count (MM:SS.cc). Its six 4-bit digit outputs drive one BCD-to-7-segment decoder per HEX display.

---
 rtl/stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timebase: debounced start/stop and lap/clear keys, centisecond
// prescaler, MM:SS.cc BCD counter with lap latch, and registered per-digit outputs.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY_SS_N,
    input  logic       KEY_LAP_N,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic [3:0] DIG2,
    output logic [3:0] DIG3,
    output logic [3:0] DIG4,
    output logic [3:0] DIG5,
    output logic       RUNNING,
    output logic       LAP_ACTIVE,
    output logic       WRAP
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLap,
        StPause
    } state_t;

    // Index 0 is start/stop, index 1 is lap/clear.
    logic [1:0]         w_key_raw;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_deb;
    logic [1:0]         r_deb_q;
    logic [1:0]         w_deb_d;
    logic [1:0][DW-1:0] r_deb_cnt;
    logic [1:0][DW-1:0] w_deb_cnt_d;
    logic [1:0]         w_press;
    logic               w_ss;
    logic               w_lap;

    state_t             r_state;
    state_t             w_state_d;
    logic               w_latch_en;
    logic               w_clear;
    logic               w_counting;
    logic               w_tick;

    logic [PW-1:0]      r_presc;
    logic [PW-1:0]      w_presc_d;
    logic [23:0]        r_cnt;
    logic [23:0]        w_cnt_d;
    logic [23:0]        w_cnt_inc;
    logic [6:0]         w_carry;
    logic [5:0]         w_at_max;
    logic [23:0]        r_lap;
    logic [23:0]        r_disp;
    logic               r_wrap;

    // ------------------------------------------------------------------
    // Button synchronisers and debouncers
    // ------------------------------------------------------------------
    assign w_key_raw = {~KEY_LAP_N, ~KEY_SS_N};

    always_comb begin
        w_deb_d     = r_deb;
        w_deb_cnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (r_sync2[k] != r_deb[k]) begin
                if (r_deb_cnt[k] == DEB_MAX) begin
                    w_deb_d[k] = r_sync2[k];
                end else begin
                    w_deb_cnt_d[k] = r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_deb_q   <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1   <= w_key_raw;
            r_sync2   <= r_sync1;
            r_deb     <= w_deb_d;
            r_deb_q   <= r_deb;
            r_deb_cnt <= w_deb_cnt_d;
        end
    end

    assign w_press = r_deb & ~r_deb_q;
    assign w_ss    = w_press[0];
    assign w_lap   = w_press[1];

    // ------------------------------------------------------------------
    // Control state machine; start/stop wins over a simultaneous lap press
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state;
        w_latch_en = 1'b0;
        w_clear    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_ss) w_state_d = StRun;
            end
            StRun: begin
                if (w_ss) begin
                    w_state_d = StPause;
                end else if (w_lap) begin
                    w_state_d  = StLap;
                    w_latch_en = 1'b1;
                end
            end
            StLap: begin
                if (w_ss) begin
                    w_state_d = StPause;
                end else if (w_lap) begin
                    w_state_d = StRun;
                end
            end
            StPause: begin
                if (w_ss) begin
                    w_state_d = StRun;
                end else if (w_lap) begin
                    w_state_d = StIdle;
                    w_clear   = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign w_counting = (r_state == StRun) || (r_state == StLap);
    assign w_tick     = w_counting && (r_presc == PRESC_MAX);

    // ------------------------------------------------------------------
    // Prescaler: holds in pause so the partial interval survives a resume
    // ------------------------------------------------------------------
    always_comb begin
        w_presc_d = r_presc;
        if (w_clear) begin
            w_presc_d = '0;
        end else if (w_counting) begin
            w_presc_d = w_tick ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Ripple BCD increment; tens-of-seconds and tens-of-minutes roll at 5
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_inc  = r_cnt;
        w_carry    = '0;
        w_at_max   = '0;
        w_carry[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_at_max[i]    = (r_cnt[4*i +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9));
            w_carry[i + 1] = w_carry[i] & w_at_max[i];
            if (w_carry[i]) begin
                w_cnt_inc[4*i +: 4] = w_at_max[i] ? 4'd0 : r_cnt[4*i +: 4] + 4'd1;
            end
        end
    end

    always_comb begin
        w_cnt_d = r_cnt;
        if (w_clear) begin
            w_cnt_d = '0;
        end else if (w_tick) begin
            w_cnt_d = w_cnt_inc;
        end
    end

    // The latch samples r_cnt, so a lap press on a tick edge keeps the pre-increment value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt  <= '0;
            r_lap  <= '0;
            r_wrap <= 1'b0;
            r_disp <= '0;
        end else begin
            r_cnt  <= w_cnt_d;
            r_wrap <= w_tick & w_carry[6];
            r_disp <= (r_state == StLap) ? r_lap : r_cnt;
            if (w_latch_en) begin
                r_lap <= r_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign DIG0       = r_disp[3:0];
    assign DIG1       = r_disp[7:4];
    assign DIG2       = r_disp[11:8];
    assign DIG3       = r_disp[15:12];
    assign DIG4       = r_disp[19:16];
    assign DIG5       = r_disp[23:20];
    assign RUNNING    = w_counting;
    assign LAP_ACTIVE = (r_state == StLap);
    assign WRAP       = r_wrap;

endmodule
